// File: rtl/crosswalk_request_conditioner.sv
// Two-channel pedestrian request conditioner: synchronise, debounce and latch
// pushbutton presses until a full green phase on the approach has served them.

module crosswalk_request_channel #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16,
    parameter int PRESS_W         = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_btn,
    input  logic               i_grn,
    output logic               o_req,
    output logic [PRESS_W-1:0] o_press_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SERVING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]   DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DB_ONE    = CNT_W'(1);
    localparam logic [PRESS_W-1:0] PRESS_ONE = PRESS_W'(1);
    localparam logic [PRESS_W-1:0] PRESS_MAX = '1;

    logic               r_s1;
    logic               r_s2;
    logic               r_stable;
    logic               r_stable_q;
    logic [CNT_W-1:0]   r_db_cnt;
    logic               r_grn_q;
    logic [PRESS_W-1:0] r_press_cnt;
    state_t             r_state;
    logic               r_repress;

    state_t             w_state_nxt;
    logic               w_repress_nxt;
    logic               w_press;
    logic               w_grn_rise;
    logic               w_grn_fall;

    // btn is fully asynchronous: plain two-flop synchroniser, then debounce.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_q <= 1'b0;
            r_db_cnt   <= '0;
            r_grn_q    <= 1'b0;
        end else begin
            r_s1       <= i_btn;
            r_s2       <= r_s1;
            r_stable_q <= r_stable;
            r_grn_q    <= i_grn;
            if (r_s2 == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_stable <= r_s2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_ONE;
            end
        end
    end

    assign w_press    = r_stable & ~r_stable_q;
    assign w_grn_rise = i_grn & ~r_grn_q;
    assign w_grn_fall = ~i_grn & r_grn_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_press_cnt <= '0;
        end else if (w_press && (r_press_cnt != PRESS_MAX)) begin
            r_press_cnt <= r_press_cnt + PRESS_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_repress <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_repress <= w_repress_nxt;
        end
    end

    // r_repress remembers a press seen mid-green so it carries to the next green.
    always_comb begin
        w_state_nxt   = r_state;
        w_repress_nxt = r_repress;
        case (r_state)
            ST_IDLE: begin
                w_repress_nxt = 1'b0;
                if (w_press) begin
                    w_state_nxt = w_grn_rise ? ST_SERVING : ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (w_grn_rise) begin
                    w_state_nxt   = ST_SERVING;
                    w_repress_nxt = 1'b0;
                end
            end
            ST_SERVING: begin
                if (w_grn_fall) begin
                    w_state_nxt   = (r_repress || w_press) ? ST_PENDING : ST_IDLE;
                    w_repress_nxt = 1'b0;
                end else if (w_press) begin
                    w_repress_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_repress_nxt = 1'b0;
            end
        endcase
    end

    assign o_req       = (r_state != ST_IDLE);
    assign o_press_cnt = r_press_cnt;

endmodule

module crosswalk_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16,
    parameter int PRESS_W         = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               btn_0,
    input  logic               btn_1,
    input  logic               grn_0,
    input  logic               grn_1,
    output logic               crosswalk_0,
    output logic               crosswalk_1,
    output logic               wait_0,
    output logic               wait_1,
    output logic [PRESS_W-1:0] press_cnt_0,
    output logic [PRESS_W-1:0] press_cnt_1
);

    localparam int NUM_CH = 2;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_param
        $error("DEBOUNCE_CYCLES out of range for CNT_W");
    end

    logic [NUM_CH-1:0]              w_btn;
    logic [NUM_CH-1:0]              w_grn;
    logic [NUM_CH-1:0]              w_req;
    logic [NUM_CH-1:0][PRESS_W-1:0] w_cnt;

    assign w_btn = {btn_1, btn_0};
    assign w_grn = {grn_1, grn_0};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        crosswalk_request_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .PRESS_W         (PRESS_W)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_btn       (w_btn[g]),
            .i_grn       (w_grn[g]),
            .o_req       (w_req[g]),
            .o_press_cnt (w_cnt[g])
        );
    end

    assign crosswalk_0 = w_req[0];
    assign crosswalk_1 = w_req[1];
    assign wait_0      = w_req[0];
    assign wait_1      = w_req[1];
    assign press_cnt_0 = w_cnt[0];
    assign press_cnt_1 = w_cnt[1];

endmodule

// File: tb/tb_crosswalk_request_conditioner.sv
// Directed + random bench for crosswalk_request_conditioner against a
// per-cycle behavioural model of debounce, press events and request service.

module tb_crosswalk_request_conditioner;

    localparam int D       = 4;
    localparam int CNT_W   = 16;
    localparam int PRESS_W = 8;
    localparam int CNT_MAX = (1 << PRESS_W) - 1;

    logic               clk;
    logic               reset_n;
    logic               btn_0, btn_1, grn_0, grn_1;
    logic               crosswalk_0, crosswalk_1, wait_0, wait_1;
    logic [PRESS_W-1:0] press_cnt_0, press_cnt_1;

    int errors = 0;
    int checks = 0;

    // Model state per approach.
    bit m_s1[2], m_s2[2], m_stable[2], m_stable_prev[2], m_gq[2];
    int m_run[2];
    bit m_req[2], m_in_green[2], m_carry[2];
    int m_cnt[2];

    crosswalk_request_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CNT_W),
        .PRESS_W         (PRESS_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_0       (btn_0),
        .btn_1       (btn_1),
        .grn_0       (grn_0),
        .grn_1       (grn_1),
        .crosswalk_0 (crosswalk_0),
        .crosswalk_1 (crosswalk_1),
        .wait_0      (wait_0),
        .wait_1      (wait_1),
        .press_cnt_0 (press_cnt_0),
        .press_cnt_1 (press_cnt_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_stable[c] = 0; m_stable_prev[c] = 0;
            m_gq[c] = 0; m_run[c] = 0; m_req[c] = 0; m_in_green[c] = 0;
            m_carry[c] = 0; m_cnt[c] = 0;
        end
    endtask

    // One clock edge worth of behaviour, using the input levels present at the edge.
    task automatic model_step();
        bit b[2];
        bit g[2];
        bit p, rise, fall;
        b[0] = btn_0; b[1] = btn_1;
        g[0] = grn_0; g[1] = grn_1;
        for (int c = 0; c < 2; c++) begin
            p    = m_stable[c] && !m_stable_prev[c];
            rise = g[c] && !m_gq[c];
            fall = !g[c] && m_gq[c];
            if (m_in_green[c]) begin
                if (p) m_carry[c] = 1;
                if (fall) begin
                    m_req[c]      = m_carry[c];
                    m_in_green[c] = 0;
                    m_carry[c]    = 0;
                end
            end else begin
                if (p) m_req[c] = 1;
                if (rise && m_req[c]) begin
                    m_in_green[c] = 1;
                    m_carry[c]    = 0;
                end
            end
            if (p && m_cnt[c] < CNT_MAX) m_cnt[c]++;
            m_stable_prev[c] = m_stable[c];
            if (m_s2[c] == m_stable[c]) m_run[c] = 0;
            else if (m_run[c] + 1 == D) begin
                m_stable[c] = m_s2[c];
                m_run[c]    = 0;
            end else m_run[c]++;
            m_s2[c] = m_s1[c];
            m_s1[c] = b[c];
            m_gq[c] = g[c];
        end
    endtask

    task automatic compare_all();
        chk("crosswalk_0", 32'(crosswalk_0), 32'(m_req[0]));
        chk("crosswalk_1", 32'(crosswalk_1), 32'(m_req[1]));
        chk("wait_0",      32'(wait_0),      32'(m_req[0]));
        chk("wait_1",      32'(wait_1),      32'(m_req[1]));
        chk("press_cnt_0", 32'(press_cnt_0), 32'(m_cnt[0]));
        chk("press_cnt_1", 32'(press_cnt_1), 32'(m_cnt[1]));
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            if (reset_n) model_step();
            else         model_reset();
            @(posedge clk);
            #1;
            compare_all();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        btn_0 = 0; btn_1 = 0; grn_0 = 0; grn_1 = 0;
        model_reset();
        #1;
        chk("reset_cw0", 32'(crosswalk_0), 0);
        chk("reset_cnt0", 32'(press_cnt_0), 0);
        tick(2);
        reset_n = 1'b1;

        // Held press on channel 0 starting at edge 10.
        tick(9);
        btn_0 = 1;
        tick(6);
        chk("lat_cw0_edge15", 32'(crosswalk_0), 0);
        tick(1);
        chk("lat_cw0_edge16", 32'(crosswalk_0), 1);
        chk("lat_wait0",      32'(wait_0), 1);
        chk("lat_cnt0",       32'(press_cnt_0), 1);
        chk("lat_cw1",        32'(crosswalk_1), 0);
        chk("lat_cnt1",       32'(press_cnt_1), 0);

        // Short glitch on channel 1 is discarded.
        btn_1 = 1; tick(3);
        btn_1 = 0; tick(20);
        chk("glitch_cw1",  32'(crosswalk_1), 0);
        chk("glitch_cnt1", 32'(press_cnt_1), 0);

        // Bouncy 10-cycle press: exactly one accepted press.
        btn_1 = 1; tick(2); btn_1 = 0; tick(2);
        btn_1 = 1; tick(10);
        btn_1 = 0; tick(2); btn_1 = 1; tick(2);
        btn_1 = 0; tick(20);
        chk("bounce_cnt1", 32'(press_cnt_1), 1);
        chk("bounce_cw1",  32'(crosswalk_1), 1);

        // Pending request served by one full green.
        grn_0 = 1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("green_hold_cw0", 32'(crosswalk_0), 1);
        end
        grn_0 = 0; tick(1);
        chk("green_fall_cw0", 32'(crosswalk_0), 0);
        btn_0 = 0; tick(10);

        // Press during green carries to the next green.
        btn_0 = 1; tick(10); btn_0 = 0; tick(10);
        grn_0 = 1; tick(2);
        btn_0 = 1; tick(8); btn_0 = 0; tick(8);
        grn_0 = 0; tick(1);
        chk("carry_cw0",  32'(crosswalk_0), 1);
        chk("carry_cnt0", 32'(press_cnt_0), 3);
        tick(3);
        grn_0 = 1; tick(5); grn_0 = 0; tick(1);
        chk("carry_clear_cw0", 32'(crosswalk_0), 0);

        // Counter saturation.
        for (int i = 0; i < 300; i++) begin
            btn_0 = 1; tick(D + 3);
            btn_0 = 0; tick(D + 3);
        end
        chk("sat_cnt0", 32'(press_cnt_0), CNT_MAX);

        // Random traffic on both approaches.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0)  btn_0 = ~btn_0;
            if ($urandom_range(0, 5) == 0)  btn_1 = ~btn_1;
            if ($urandom_range(0, 14) == 0) grn_0 = ~grn_0;
            if ($urandom_range(0, 14) == 0) grn_1 = ~grn_1;
            tick(1);
        end
        grn_0 = 0; grn_1 = 0;
        btn_0 = 0; btn_1 = 0; tick(12);

        // Asynchronous reset mid-debounce with a request pending.
        btn_0 = 1; tick(D + 3);
        btn_1 = 1; tick(4);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_cw0",   32'(crosswalk_0), 0);
        chk("arst_wait0", 32'(wait_0), 0);
        chk("arst_cnt0",  32'(press_cnt_0), 0);
        chk("arst_cw1",   32'(crosswalk_1), 0);
        chk("arst_cnt1",  32'(press_cnt_1), 0);
        tick(1);
        reset_n = 1'b1;
        tick(D + 2);
        chk("rel_cw0_early", 32'(crosswalk_0), 0);
        tick(1);
        chk("rel_cw0",  32'(crosswalk_0), 1);
        chk("rel_cnt0", 32'(press_cnt_0), 1);
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
